// File: rtl/pulse_monitor.sv
// pulse_monitor: measures total sig_in high and low cycles over NUM_PULSES
// complete periods and presents the result with a valid/ready handshake.
// Optional feature: define PULSE_MONITOR_TIMEOUT_EN to end a run with the
// timeout flag set when no rising edge arrives within TIMEOUT cycles.
module pulse_monitor #(
    parameter int WIDTH      = 8,
    parameter int NUM_PULSES = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] high_width,
    output logic [WIDTH-1:0] low_width,
    output logic [WIDTH-1:0] pulse_count,
    output logic             timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [WIDTH-1:0] MAXV      = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST_EDGE = WIDTH'(NUM_PULSES - 1);

    logic [1:0] state;
    logic       sig_q;
    logic       rise;
    logic       idle_expire;

    assign rise = sig_in & ~sig_q;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == MAXV) ? v : v + ONE;
    endfunction

`ifdef PULSE_MONITOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] idle_cnt;
    logic          timeout_q;

    assign idle_expire = ~rise & (idle_cnt == CNT_LAST);
    assign timeout     = timeout_q;

    // Count cycles since the last rising edge while a run is waiting for edges.
    always_ff @(posedge clk) begin
        if (rst || rise || !(state == ARMED || state == MEASURE))
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + CNT_ONE;
    end

    // Timeout flag: cleared when a run starts, set when a run ends by timeout.
    always_ff @(posedge clk) begin
        if (rst)
            timeout_q <= 1'b0;
        else if (state == IDLE && enable)
            timeout_q <= 1'b0;
        else if (enable && (state == ARMED || state == MEASURE) && idle_expire)
            timeout_q <= 1'b1;
    end
`else
    assign idle_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Run-control FSM plus saturating period accumulators and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sig_q        <= 1'b0;
            result_valid <= 1'b0;
            high_width   <= '0;
            low_width    <= '0;
            pulse_count  <= '0;
        end else begin
            sig_q <= sig_in;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= ARMED;
                        high_width  <= '0;
                        low_width   <= '0;
                        pulse_count <= '0;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (rise) begin
                        // The first rise opens period 1 and is itself a high cycle.
                        state      <= MEASURE;
                        high_width <= ONE;
                    end else if (idle_expire) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (rise) begin
                        pulse_count <= pulse_count + ONE;
                        if (pulse_count == LAST_EDGE) begin
                            // Terminating rise closes the last period; not accumulated.
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            high_width <= sat_inc(high_width);
                        end
                    end else begin
                        if (sig_in)
                            high_width <= sat_inc(high_width);
                        else
                            low_width <= sat_inc(low_width);
                        if (idle_expire) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: randomized and directed stimulus for pulse_monitor,
// checked against a period-level reference model of the expected result.
module tb_pulse_monitor;

    localparam int WIDTH = 8;
    localparam int NP    = 4;
    localparam int TMO   = 200;
    localparam int SATV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             sig_in;
    logic             result_ready;
    logic             result_valid;
    logic [WIDTH-1:0] high_width;
    logic [WIDTH-1:0] low_width;
    logic [WIDTH-1:0] pulse_count;
    logic             timeout;

    int checks = 0;
    int passed = 0;
    bit wave[$];

    always #5 clk = ~clk;

    pulse_monitor #(
        .WIDTH(WIDTH),
        .NUM_PULSES(NP),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sig_in(sig_in),
        .result_ready(result_ready),
        .result_valid(result_valid),
        .high_width(high_width),
        .low_width(low_width),
        .pulse_count(pulse_count),
        .timeout(timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: locate rising edges in the waveform (line idle low before it),
    // the result covers cycles from the first rise up to the NP-th later rise.
    function automatic void model(output int end_idx, output int hi, output int lo);
        int rises[$];
        bit prev = 1'b0;
        foreach (wave[i]) begin
            if (wave[i] && !prev) rises.push_back(i);
            prev = wave[i];
        end
        end_idx = -1;
        hi = 0;
        lo = 0;
        if (rises.size() > NP) begin
            end_idx = rises[NP];
            for (int i = rises[0]; i < end_idx; i++) begin
                if (wave[i]) hi++;
                else lo++;
            end
        end
        if (hi > SATV) hi = SATV;
        if (lo > SATV) lo = SATV;
    endfunction

    task automatic add_period(input int h, input int l);
        repeat (h) wave.push_back(1'b1);
        repeat (l) wave.push_back(1'b0);
    endtask

    task automatic build_square(input int h, input int l);
        wave.delete();
        for (int p = 0; p < NP; p++) add_period(h, l);
        wave.push_back(1'b1);
    endtask

    // Optionally arm, then drive the waveform until result_valid is seen.
    task automatic run_wave(input bit do_arm, output int first);
        if (do_arm) begin
            sig_in = 1'b0;
            enable = 1'b1;
            step();
        end
        first = -1;
        for (int i = 0; i < wave.size(); i++) begin
            sig_in = wave[i];
            step();
            if (result_valid === 1'b1) begin
                first = i;
                break;
            end
        end
    endtask

    task automatic go_idle();
        enable       = 1'b0;
        sig_in       = 1'b0;
        result_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; sig_in = 1'b1; result_ready = 1'b1;
        step();
        step();
        checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", result_valid); else passed++;
        checks++; if (high_width !== '0) $display("FAIL reset_high got %0d exp 0", high_width); else passed++;
        checks++; if (low_width !== '0) $display("FAIL reset_low got %0d exp 0", low_width); else passed++;
        checks++; if (pulse_count !== '0) $display("FAIL reset_count got %0d exp 0", pulse_count); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %0b exp 0", timeout); else passed++;
        rst = 1'b0; enable = 1'b0; sig_in = 1'b0;
        step();
    endtask

    // Square 3/5, random waveforms, and 300/300 saturation, all with ready=1.
    task automatic test_measure();
        int first, exp_end, hi, lo;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                build_square(3, 5);
            end else if (k == 7) begin
                build_square(300, 300);
            end else begin
                wave.delete();
                repeat ($urandom_range(0, 4)) wave.push_back(1'b0);
                for (int p = 0; p < NP; p++) add_period($urandom_range(1, 6), $urandom_range(1, 6));
                wave.push_back(1'b1);
            end
            model(exp_end, hi, lo);
            if (k == 0) begin
                checks++; if (hi !== 12 || lo !== 20) $display("FAIL model_square got %0d/%0d exp 12/20", hi, lo); else passed++;
            end
            result_ready = 1'b1;
            run_wave(1'b1, first);
            checks++; if (first !== exp_end) $display("FAIL run%0d_latency got %0d exp %0d", k, first, exp_end); else passed++;
            checks++; if (high_width !== WIDTH'(hi)) $display("FAIL run%0d_high got %0d exp %0d", k, high_width, hi); else passed++;
            checks++; if (low_width !== WIDTH'(lo)) $display("FAIL run%0d_low got %0d exp %0d", k, low_width, lo); else passed++;
            checks++; if (pulse_count !== WIDTH'(NP)) $display("FAIL run%0d_count got %0d exp %0d", k, pulse_count, NP); else passed++;
            checks++; if (timeout !== 1'b0) $display("FAIL run%0d_timeout got %0b exp 0", k, timeout); else passed++;
            enable = 1'b0; sig_in = 1'b0;
            step();
            checks++; if (result_valid !== 1'b0) $display("FAIL run%0d_release got %0b exp 0", k, result_valid); else passed++;
            step();
        end
    endtask

    // Result held stable while ready is low, even with enable dropped.
    task automatic test_hold();
        int first, exp_end, hi, lo;
        build_square(3, 5);
        model(exp_end, hi, lo);
        result_ready = 1'b0;
        run_wave(1'b1, first);
        checks++; if (first !== exp_end) $display("FAIL hold_latency got %0d exp %0d", first, exp_end); else passed++;
        for (int c = 0; c < 10; c++) begin
            sig_in = 1'b0;
            if (c == 4) enable = 1'b0;
            step();
            checks++;
            if (result_valid !== 1'b1 || high_width !== WIDTH'(hi) || low_width !== WIDTH'(lo) || pulse_count !== WIDTH'(NP))
                $display("FAIL hold_cycle%0d got v%0b h%0d l%0d c%0d exp v1 h%0d l%0d c%0d",
                         c, result_valid, high_width, low_width, pulse_count, hi, lo, NP);
            else passed++;
        end
        result_ready = 1'b1;
        step();
        checks++; if (result_valid !== 1'b0) $display("FAIL hold_release got %0b exp 0", result_valid); else passed++;
        go_idle();
    endtask

    // Enable held across a handshake: fields hold in IDLE, then clear as the next run arms.
    task automatic test_back_to_back();
        int first, exp_end, hi, lo;
        build_square(2, 4);
        model(exp_end, hi, lo);
        result_ready = 1'b1;
        run_wave(1'b1, first);
        checks++; if (first !== exp_end) $display("FAIL b2b_first_latency got %0d exp %0d", first, exp_end); else passed++;
        sig_in = 1'b0;
        step();
        checks++; if (result_valid !== 1'b0 || high_width !== WIDTH'(hi)) $display("FAIL b2b_idle_hold got v%0b h%0d exp v0 h%0d", result_valid, high_width, hi); else passed++;
        step();
        checks++; if (high_width !== '0 || pulse_count !== '0) $display("FAIL b2b_arm_clear got h%0d c%0d exp 0 0", high_width, pulse_count); else passed++;
        build_square(4, 1);
        model(exp_end, hi, lo);
        run_wave(1'b0, first);
        checks++; if (first !== exp_end) $display("FAIL b2b_second_latency got %0d exp %0d", first, exp_end); else passed++;
        checks++; if (high_width !== WIDTH'(hi) || low_width !== WIDTH'(lo)) $display("FAIL b2b_second_fields got %0d/%0d exp %0d/%0d", high_width, low_width, hi, lo); else passed++;
        go_idle();
    endtask

    task automatic test_abort();
        int nvalid, first, exp_end, hi, lo;
        build_square(3, 5);
        model(exp_end, hi, lo);
        result_ready = 1'b1;
        // Drop enable inside the second period.
        sig_in = 1'b0; enable = 1'b1;
        step();
        nvalid = 0;
        for (int i = 0; i < wave.size() + 20; i++) begin
            sig_in = (i < wave.size()) ? wave[i] : 1'b0;
            if (i == 11) enable = 1'b0;
            step();
            if (result_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) $display("FAIL abort_mid got %0d valid cycles exp 0", nvalid); else passed++;
        // Drop enable exactly on the terminating rise.
        sig_in = 1'b0; enable = 1'b1;
        step();
        nvalid = 0;
        for (int i = 0; i < wave.size() + 20; i++) begin
            sig_in = (i < wave.size()) ? wave[i] : 1'b0;
            if (i == exp_end) enable = 1'b0;
            step();
            if (result_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) $display("FAIL abort_terminal got %0d valid cycles exp 0", nvalid); else passed++;
        sig_in = 1'b0;
        step();
        run_wave(1'b1, first);
        checks++; if (first !== exp_end || pulse_count !== WIDTH'(NP)) $display("FAIL abort_recover got idx%0d c%0d exp idx%0d c%0d", first, pulse_count, exp_end, NP); else passed++;
        go_idle();
    endtask

    task automatic test_reset_mid();
        build_square(3, 5);
        sig_in = 1'b0; enable = 1'b1; result_ready = 1'b0;
        step();
        for (int i = 0; i < 12; i++) begin
            sig_in = wave[i];
            step();
        end
        checks++; if (high_width === '0) $display("FAIL midrun_active got h%0d exp nonzero", high_width); else passed++;
        rst = 1'b1;
        step();
        checks++;
        if (result_valid !== 1'b0 || high_width !== '0 || low_width !== '0 || pulse_count !== '0 || timeout !== 1'b0)
            $display("FAIL midrun_reset got v%0b h%0d l%0d c%0d t%0b exp all 0", result_valid, high_width, low_width, pulse_count, timeout);
        else passed++;
        rst = 1'b0;
        go_idle();
    endtask

    task automatic test_stuck_low();
        int first;
        sig_in = 1'b0; enable = 1'b1; result_ready = 1'b0;
        step();
        first = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (result_valid === 1'b1) begin
                first = i;
                break;
            end
        end
`ifdef PULSE_MONITOR_TIMEOUT_EN
        checks++; if (first !== TMO - 1) $display("FAIL stuck_latency got %0d exp %0d", first, TMO - 1); else passed++;
        checks++; if (timeout !== 1'b1 || pulse_count !== '0) $display("FAIL stuck_fields got t%0b c%0d exp t1 c0", timeout, pulse_count); else passed++;
`else
        checks++; if (first !== -1) $display("FAIL stuck_novalid got idx %0d exp none", first); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL stuck_timeout got %0b exp 0", timeout); else passed++;
`endif
        go_idle();
    endtask

    initial begin
        test_reset();
        test_measure();
        test_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_stuck_low();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
